// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - phase/transition types and the quadrature step classifier
package quad_pkg;

    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S11 = 2'b11,
        S10 = 2'b10
    } phase_t;

    typedef enum logic [1:0] {
        X_NONE,
        X_UP,
        X_DOWN,
        X_ILLEGAL
    } xfer_t;

    // Successor of a phase in the counting-up direction: S00->S01->S11->S10->S00.
    function automatic phase_t next_up(input phase_t p);
        phase_t n;
        case (p)
            S00:     n = S01;
            S01:     n = S11;
            S11:     n = S10;
            S10:     n = S00;
            default: n = S00;
        endcase
        return n;
    endfunction

    // Gray-code property: a legal step flips exactly one bit, so any step that is
    // neither "no change" nor "both bits" is either the up successor or the down one.
    function automatic xfer_t classify(input phase_t prev, input phase_t cur);
        logic [1:0] diff;
        diff = prev ^ cur;
        if (diff == 2'b00)
            return X_NONE;
        else if (diff == 2'b11)
            return X_ILLEGAL;
        else if (next_up(prev) == cur)
            return X_UP;
        else
            return X_DOWN;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - W-bit two-flop synchronizer, no reset
//  clk   in  clock of the receiving domain
//  d     in  W-bit asynchronous input
//  q     out W-bit synchronized output (two clk of latency)
module sync_2ff #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;
    logic [W-1:0] stable;

    // Deliberately unreset so the chain keeps sampling the pins while rst is held.
    always_ff @(posedge clk) begin
        meta   <= d;
        stable <= meta;
    end

    assign q = stable;

endmodule

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - quadrature A/B receiver with direction, step pulse and position count
//  clk         in   single clock, posedge
//  rst         in   synchronous reset, active-high
//  quad_a      in   phase A, asynchronous
//  quad_b      in   phase B, asynchronous
//  en          in   1 = count legal steps, 0 = track phase/direction only
//  step        out  one-cycle pulse per counted legal transition
//  UorD        out  direction of the last legal transition, 1 = up
//  count       out  wrap-around position count
//  err         out  one-cycle pulse when both phases changed together
//  err_sticky  out  latched err, cleared only by rst
module quad_decoder
    import quad_pkg::*;
#(
    parameter int length = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              quad_a,
    input  logic              quad_b,
    input  logic              en,
    output logic              step,
    output logic              UorD,
    output logic [length-1:0] count,
    output logic              err,
    output logic              err_sticky
);

    localparam logic [length-1:0] COUNT_ONE = {{(length-1){1'b0}}, 1'b1};

    logic [1:0] sync_ab;
    phase_t     cur_phase;
    phase_t     prev_phase;
    xfer_t      xfer;

    sync_2ff #(.W(2)) u_sync (
        .clk (clk),
        .d   ({quad_a, quad_b}),
        .q   (sync_ab)
    );

    assign cur_phase = phase_t'(sync_ab);
    assign xfer      = classify(prev_phase, cur_phase);

    // Tracks the synchronized phase even during reset, so releasing rst never
    // sees a stale previous phase and cannot produce a spurious step or err.
    always_ff @(posedge clk) begin
        prev_phase <= cur_phase;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            UorD       <= 1'b1;
            step       <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            step <= 1'b0;
            err  <= 1'b0;
            case (xfer)
                X_UP: begin
                    UorD <= 1'b1;
                    if (en) begin
                        step  <= 1'b1;
                        count <= count + COUNT_ONE;
                    end
                end
                X_DOWN: begin
                    UorD <= 1'b0;
                    if (en) begin
                        step  <= 1'b1;
                        count <= count - COUNT_ONE;
                    end
                end
                X_ILLEGAL: begin
                    err        <= 1'b1;
                    err_sticky <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - table-driven self-checking bench for quad_decoder
module tb_quad_decoder;

    logic       clk;
    logic       rst;
    logic       quad_a;
    logic       quad_b;
    logic       en;
    logic       step;
    logic       UorD;
    logic [3:0] count;
    logic       err;
    logic       err_sticky;

    int n_total = 0;
    int n_pass  = 0;

    quad_decoder #(.length(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .quad_a     (quad_a),
        .quad_b     (quad_b),
        .en         (en),
        .step       (step),
        .UorD       (UorD),
        .count      (count),
        .err        (err),
        .err_sticky (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        logic  a;
        logic  b;
        logic  en;
        int    exp_count;
        logic  exp_uord;
        logic  exp_sticky;
        int    exp_steps;
        int    exp_errs;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input string name, input logic a, input logic b, input logic e,
                                input int c, input logic u, input logic s,
                                input int st, input int er);
        vec_t v;
        v.name = name; v.a = a; v.b = b; v.en = e;
        v.exp_count = c; v.exp_uord = u; v.exp_sticky = s;
        v.exp_steps = st; v.exp_errs = er;
        return v;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Drive pins at a negedge, then sample four negedges. A change before posedge k
    // must show its step/err in the third sample (after posedge k+2).
    task automatic apply(input logic a, input logic b, input logic e,
                         output int steps, output int errs, output int first_idx);
        steps = 0; errs = 0; first_idx = -1;
        quad_a = a; quad_b = b; en = e;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (step) begin
                steps++;
                if (first_idx < 0) first_idx = i;
            end
            if (err) begin
                errs++;
                if (first_idx < 0) first_idx = i;
            end
        end
    endtask

    initial begin
        int steps, errs, fidx, tot_steps, tot_errs, mcount;
        logic [1:0] up_seq [4];

        // Reset: 3 clk with A=B=0
        rst = 1'b1; quad_a = 1'b0; quad_b = 1'b0; en = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_count", count, 0);
        check("reset_uord", UorD, 1);
        check("reset_step", step, 0);
        check("reset_err", err, 0);
        check("reset_sticky", err_sticky, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        //                  name       a     b     en    cnt u     stk   st er
        vq.push_back(mk("fwd_01",   1'b0, 1'b1, 1'b1,  1, 1'b1, 1'b0, 1, 0));
        vq.push_back(mk("fwd_11",   1'b1, 1'b1, 1'b1,  2, 1'b1, 1'b0, 1, 0));
        vq.push_back(mk("fwd_10",   1'b1, 1'b0, 1'b1,  3, 1'b1, 1'b0, 1, 0));
        vq.push_back(mk("fwd_00",   1'b0, 1'b0, 1'b1,  4, 1'b1, 1'b0, 1, 0));
        vq.push_back(mk("rev_10",   1'b1, 1'b0, 1'b1,  3, 1'b0, 1'b0, 1, 0));
        vq.push_back(mk("rev_11",   1'b1, 1'b1, 1'b1,  2, 1'b0, 1'b0, 1, 0));
        vq.push_back(mk("rev_01",   1'b0, 1'b1, 1'b1,  1, 1'b0, 1'b0, 1, 0));
        vq.push_back(mk("rev_00",   1'b0, 1'b0, 1'b1,  0, 1'b0, 1'b0, 1, 0));
        vq.push_back(mk("wrap_dn",  1'b1, 1'b0, 1'b1, 15, 1'b0, 1'b0, 1, 0));
        vq.push_back(mk("back_00",  1'b0, 1'b0, 1'b1,  0, 1'b1, 1'b0, 1, 0));

        foreach (vq[i]) begin
            apply(vq[i].a, vq[i].b, vq[i].en, steps, errs, fidx);
            check({vq[i].name, "_count"}, count, vq[i].exp_count);
            check({vq[i].name, "_uord"}, UorD, vq[i].exp_uord);
            check({vq[i].name, "_sticky"}, err_sticky, vq[i].exp_sticky);
            check({vq[i].name, "_steps"}, steps, vq[i].exp_steps);
            check({vq[i].name, "_errs"}, errs, vq[i].exp_errs);
            if (vq[i].exp_steps + vq[i].exp_errs > 0)
                check({vq[i].name, "_latency"}, fidx, 2);
        end

        // Wrap up: 16 forward steps from count 0
        up_seq[0] = 2'b01; up_seq[1] = 2'b11; up_seq[2] = 2'b10; up_seq[3] = 2'b00;
        tot_steps = 0; tot_errs = 0; mcount = 0;
        for (int i = 0; i < 16; i++) begin
            apply(up_seq[i % 4][1], up_seq[i % 4][0], 1'b1, steps, errs, fidx);
            tot_steps += steps;
            tot_errs  += errs;
            mcount = (mcount + 1) % 16;
            check("wrap_up_count", count, mcount);
        end
        check("wrap_up_steps", tot_steps, 16);
        check("wrap_up_errs", tot_errs, 0);
        check("wrap_up_final", count, 0);

        // Illegal jump, then en=0 tracking, then counting resumes
        vq.delete();
        vq.push_back(mk("illegal",  1'b1, 1'b1, 1'b1,  0, 1'b1, 1'b1, 0, 1));
        vq.push_back(mk("en0_dn01", 1'b0, 1'b1, 1'b0,  0, 1'b0, 1'b1, 0, 0));
        vq.push_back(mk("en0_dn00", 1'b0, 1'b0, 1'b0,  0, 1'b0, 1'b1, 0, 0));
        vq.push_back(mk("en0_up01", 1'b0, 1'b1, 1'b0,  0, 1'b1, 1'b1, 0, 0));
        vq.push_back(mk("en0_up11", 1'b1, 1'b1, 1'b0,  0, 1'b1, 1'b1, 0, 0));
        vq.push_back(mk("en1_up10", 1'b1, 1'b0, 1'b1,  1, 1'b1, 1'b1, 1, 0));
        foreach (vq[i]) begin
            apply(vq[i].a, vq[i].b, vq[i].en, steps, errs, fidx);
            check({vq[i].name, "_count"}, count, vq[i].exp_count);
            check({vq[i].name, "_uord"}, UorD, vq[i].exp_uord);
            check({vq[i].name, "_sticky"}, err_sticky, vq[i].exp_sticky);
            check({vq[i].name, "_steps"}, steps, vq[i].exp_steps);
            check({vq[i].name, "_errs"}, errs, vq[i].exp_errs);
            if (vq[i].exp_steps + vq[i].exp_errs > 0)
                check({vq[i].name, "_latency"}, fidx, 2);
        end

        // Reset mid-run: pins step 10->11 (down) in the same cycle rst rises
        rst = 1'b1; quad_a = 1'b1; quad_b = 1'b1; en = 1'b1;
        steps = 0; errs = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (step) steps++;
            if (err) errs++;
        end
        check("midrst_steps", steps, 0);
        check("midrst_errs", errs, 0);
        rst = 1'b0;
        steps = 0; errs = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (step) steps++;
            if (err) errs++;
        end
        check("post_rst_steps", steps, 0);
        check("post_rst_errs", errs, 0);
        check("post_rst_count", count, 0);
        check("post_rst_uord", UorD, 1);
        check("post_rst_sticky", err_sticky, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
